// File: rtl/uart_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_axil_pkg
// Purpose  : Shared definitions for the UART AXI4-Lite scheduler. Holds the
//            UART register map, the AXI response encoding, the scheduler FSM
//            state encoding and a pointer-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_axil_pkg;

    // UART register offsets (byte addresses on the AXI4-Lite slave port)
    localparam logic [7:0] OFF_TX_DATA  = 8'h00;   // write: byte to transmit
    localparam logic [7:0] OFF_TX_BUSY  = 8'h04;   // read: bit0 = transmitter busy
    localparam logic [7:0] OFF_RX_DATA  = 8'h08;   // read: received byte, clears drdy
    localparam logic [7:0] OFF_RX_STATE = 8'h0C;   // read: bit0 = drdy, bit1 = rx_busy

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POLL_RX  = 3'd1,
        ST_READ_RX  = 3'd2,
        ST_POLL_TX  = 3'd3,
        ST_WRITE_TX = 3'd4,
        ST_GUARD    = 3'd5
    } state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Grants the lowest requester index
//            at or after ptr (wrapping modulo N) whose request is set.
// Ports    : req       - per-requester request bits
//            ptr       - index that has highest priority this round
//            grant_idx - chosen index (0 when nothing is requested)
//            grant_any - at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_axil_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant_idx,
    output logic          grant_any
);

    logic [PW-1:0] pos;

    // Scan from the farthest offset down to offset zero so the candidate
    // closest to ptr is the last one written and therefore wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = PW'((int'(ptr) + k) % N);
            if (req[pos]) begin
                grant_idx = pos;
                grant_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_axil_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_axil_sched
// Purpose  : AXI4-Lite master that drives a uart_axi4lite peripheral for a set
//            of on-chip byte producers and one byte consumer. TX requesters
//            are served round-robin, each TX_DATA write is preceded by a
//            TX_BUSY poll, and received bytes are drained into a one-entry
//            output buffer. At most one AXI transaction is outstanding.
// Ports    : AXI_ACLK / AXI_ARESETN      - clock, async active-low reset
//            REQ_VALID/REQ_DATA/REQ_READY - TX requester handshake (ready is
//                                           a one-cycle accept pulse)
//            RX_VALID/RX_DATA/RX_READY    - received-byte output buffer
//            ERR                          - sticky non-OKAY response flag
//            M_AXI_*                      - AXI4-Lite master channels
// Revision : 1.0 - initial release
// ============================================================================
module uart_axil_sched
    import uart_axil_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32,
    parameter int DATA_BITS  = 8,
    parameter int TX_GUARD   = 4
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESETN,

    input  logic [NUM_REQ-1:0]          REQ_VALID,
    input  logic [NUM_REQ*DATA_BITS-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]          REQ_READY,

    output logic                        RX_VALID,
    output logic [DATA_BITS-1:0]        RX_DATA,
    input  logic                        RX_READY,

    output logic                        ERR,

    output logic [AXI_AWIDTH-1:0]       M_AXI_AWADDR,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]       M_AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0]     M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]       M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]       M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = $clog2(TX_GUARD + 1);

    state_t state, state_next;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  started;    // transaction of the current state issued
    logic                  aw_done;
    logic                  w_done;
    logic [CNT_W-1:0]      guard_cnt;
    logic                  guard_done;
    logic                  rd_hs;
    logic                  wr_hs;
    logic                  any_req;
    logic                  is_read_state;
    logic                  leaving;
    logic [AXI_AWIDTH-1:0] rd_addr;
    logic                  unused_rdata;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (REQ_VALID),
        .ptr       (rr_ptr),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Write strobes never change: every TX_DATA write is a full word.
    assign M_AXI_WSTRB = '1;

    assign rd_hs         = M_AXI_RVALID & M_AXI_RREADY;
    assign wr_hs         = M_AXI_BVALID & M_AXI_BREADY;
    assign any_req       = |REQ_VALID;
    assign guard_done    = (guard_cnt == CNT_W'(TX_GUARD - 1));
    assign is_read_state = (state == ST_POLL_RX) || (state == ST_READ_RX) ||
                           (state == ST_POLL_TX);
    assign leaving       = (state_next != state);
    // Only bit0 and the low byte of RDATA carry information for this master.
    assign unused_rdata  = ^M_AXI_RDATA;

    always_comb begin
        rd_addr = AXI_AWIDTH'(OFF_TX_BUSY);
        case (state)
            ST_POLL_RX: rd_addr = AXI_AWIDTH'(OFF_RX_STATE);
            ST_READ_RX: rd_addr = AXI_AWIDTH'(OFF_RX_DATA);
            default:    rd_addr = AXI_AWIDTH'(OFF_TX_BUSY);
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register + next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                // RX is checked first whenever the output buffer has room.
                if (!RX_VALID) begin
                    state_next = ST_POLL_RX;
                end else if (any_req) begin
                    state_next = ST_POLL_TX;
                end
            end
            ST_POLL_RX: begin
                if (rd_hs) begin
                    if (M_AXI_RDATA[0]) begin
                        state_next = ST_READ_RX;
                    end else begin
                        state_next = any_req ? ST_POLL_TX : ST_IDLE;
                    end
                end
            end
            ST_READ_RX: begin
                if (rd_hs) begin
                    state_next = any_req ? ST_POLL_TX : ST_IDLE;
                end
            end
            ST_POLL_TX: begin
                // Busy transmitter or no requester left: go back and re-poll RX.
                if (rd_hs) begin
                    state_next = (!M_AXI_RDATA[0] && arb_any) ? ST_WRITE_TX : ST_IDLE;
                end
            end
            ST_WRITE_TX: begin
                if (wr_hs) begin
                    state_next = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (guard_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // AXI channels, grant bookkeeping, RX buffer and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            started       <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            guard_cnt     <= '0;
            rr_ptr        <= '0;
            grant         <= '0;
            REQ_READY     <= '0;
            RX_VALID      <= 1'b0;
            RX_DATA       <= '0;
            ERR           <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            // One transaction per visit of a bus state; the flag re-arms on
            // every state change so the next state issues its own access.
            if (leaving) begin
                started <= 1'b0;
            end else if ((is_read_state || state == ST_WRITE_TX) && !started) begin
                started <= 1'b1;
            end

            // Read channel: RREADY goes up with ARVALID because the slave
            // only returns data while RREADY is high.
            if (is_read_state && !started) begin
                M_AXI_ARADDR  <= rd_addr;
                M_AXI_ARVALID <= 1'b1;
                M_AXI_RREADY  <= 1'b1;
            end else begin
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    M_AXI_ARVALID <= 1'b0;
                end
                if (rd_hs) begin
                    M_AXI_RREADY <= 1'b0;
                end
            end

            // Write channel: AW and W complete independently of each other.
            if (state == ST_WRITE_TX && !started) begin
                M_AXI_AWADDR  <= AXI_AWIDTH'(OFF_TX_DATA);
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                M_AXI_BREADY  <= 1'b1;
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
            end else begin
                if (!aw_done && M_AXI_AWVALID && M_AXI_AWREADY) begin
                    M_AXI_AWVALID <= 1'b0;
                    aw_done       <= 1'b1;
                end
                if (!w_done && M_AXI_WVALID && M_AXI_WREADY) begin
                    M_AXI_WVALID <= 1'b0;
                    w_done       <= 1'b1;
                end
                if (wr_hs) begin
                    M_AXI_BREADY <= 1'b0;
                end
            end

            // Arbitration is resolved when the TX_BUSY read returns idle.
            if (state == ST_POLL_TX && rd_hs && !M_AXI_RDATA[0] && arb_any) begin
                grant       <= arb_idx;
                M_AXI_WDATA <= AXI_DWIDTH'(REQ_DATA[arb_idx*DATA_BITS +: DATA_BITS]);
            end

            // A rejected write leaves the pointer alone so the same byte is retried.
            REQ_READY <= '0;
            if (state == ST_WRITE_TX && wr_hs) begin
                if (M_AXI_BRESP == RESP_OKAY) begin
                    REQ_READY[grant] <= 1'b1;
                    rr_ptr <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + PTR_W'(1);
                end else begin
                    ERR <= 1'b1;
                end
            end
            if (rd_hs && M_AXI_RRESP != RESP_OKAY) begin
                ERR <= 1'b1;
            end

            if (state == ST_READ_RX && rd_hs) begin
                RX_DATA  <= M_AXI_RDATA[DATA_BITS-1:0];
                RX_VALID <= 1'b1;
            end else if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end

            if (state == ST_GUARD && !guard_done) begin
                guard_cnt <= guard_cnt + CNT_W'(1);
            end else begin
                guard_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_axil_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_axil_sched
// Purpose  : Directed self-checking bench for uart_axil_sched. A register-level
//            model of the UART slave answers the AXI accesses and logs them;
//            requesters drop REQ_VALID when their REQ_READY pulse is seen.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_axil_sched;
    import uart_axil_pkg::*;

    localparam int NR = 4;

    logic              clk;
    logic              AXI_ARESETN;
    logic [NR-1:0]     REQ_VALID;
    logic [NR*8-1:0]   REQ_DATA;
    logic [NR-1:0]     REQ_READY;
    logic              RX_VALID;
    logic [7:0]        RX_DATA;
    logic              RX_READY;
    logic              ERR;
    logic [3:0]        AWADDR;
    logic              AWVALID, AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID, WREADY;
    logic [1:0]        BRESP;
    logic              BVALID, BREADY;
    logic [3:0]        ARADDR;
    logic              ARVALID, ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID, RREADY;

    uart_axil_sched #(
        .NUM_REQ(NR), .AXI_AWIDTH(4), .AXI_DWIDTH(32), .DATA_BITS(8), .TX_GUARD(4)
    ) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(AXI_ARESETN),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
        .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY), .ERR(ERR),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID),
        .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
        .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    // ---------------- slave model state ----------------
    logic        ar_hs_p, r_hs_p, aw_hs_p, w_hs_p, b_hs_p;
    logic [3:0]  ar_addr_p, rd_addr;
    logic        have_rd, aw_got, w_got;
    logic [31:0] w_data_p, w_data;
    int          tx_busy_cnt;
    logic        drdy;
    logic [7:0]  rx_byte;
    logic        err_next;
    int          aw_stall_cfg, aw_stall_cnt;
    int          last_rd_addr, prev_rd_addr;
    logic [31:0] last_rd_data;
    int          rd_log[$];
    logic [31:0] wr_log[$];
    logic [1:0]  wr_resp[$];
    int          wr_prev1[$];
    int          wr_prev2[$];
    logic [31:0] wr_prevd[$];
    int          ready_cnt[NR];

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int count_rd(input int a);
        int n;
        n = 0;
        foreach (rd_log[i]) if (rd_log[i] == a) n++;
        return n;
    endfunction

    task automatic clear_logs();
        rd_log.delete(); wr_log.delete(); wr_resp.delete();
        wr_prev1.delete(); wr_prev2.delete(); wr_prevd.delete();
        for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
    endtask

    // Slave: acts on handshakes decided at the previous falling edge, then
    // drives new ready/valid values that the next rising edge will sample.
    initial begin
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ar_hs_p = 0; r_hs_p = 0; aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0;
        ar_addr_p = 0; rd_addr = 0; have_rd = 0; aw_got = 0; w_got = 0;
        w_data_p = 0; w_data = 0; tx_busy_cnt = 0; aw_stall_cnt = 0;
        last_rd_addr = -1; prev_rd_addr = -1; last_rd_data = 0;
        forever begin
            @(negedge clk);
            if (!AXI_ARESETN) begin
                ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
                ar_hs_p = 0; r_hs_p = 0; aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0;
                have_rd = 0; aw_got = 0; w_got = 0;
                continue;
            end
            for (int i = 0; i < NR; i++) begin
                if (REQ_READY[i]) begin
                    ready_cnt[i]++;
                    REQ_VALID[i] = 1'b0;
                end
            end
            if (tx_busy_cnt > 0) tx_busy_cnt--;
            // read channel
            if (ar_hs_p) begin ARREADY = 0; have_rd = 1; rd_addr = ar_addr_p; end
            if (r_hs_p) RVALID = 0;
            if (have_rd && !RVALID && RREADY) begin
                case (rd_addr)
                    4'h4:    RDATA = {31'd0, (tx_busy_cnt > 0)};
                    4'h8:    begin RDATA = {24'd0, rx_byte}; drdy = 1'b0; end
                    4'hC:    RDATA = {31'd0, drdy};
                    default: RDATA = 32'd0;
                endcase
                RRESP = 2'b00; RVALID = 1; have_rd = 0;
                rd_log.push_back(int'(rd_addr));
                prev_rd_addr = last_rd_addr;
                last_rd_addr = int'(rd_addr);
                last_rd_data = RDATA;
            end
            if (ARVALID && !ARREADY && !have_rd && !RVALID) ARREADY = 1;
            // write channel
            if (aw_hs_p) begin AWREADY = 0; aw_got = 1; end
            if (w_hs_p) begin WREADY = 0; w_got = 1; w_data = w_data_p; aw_stall_cnt = aw_stall_cfg; end
            if (b_hs_p) BVALID = 0;
            if (aw_got && w_got && !BVALID) begin
                BRESP = err_next ? 2'b10 : 2'b00;
                BVALID = 1;
                wr_log.push_back(w_data);
                wr_resp.push_back(BRESP);
                wr_prev1.push_back(last_rd_addr);
                wr_prev2.push_back(prev_rd_addr);
                wr_prevd.push_back(last_rd_data);
                if (!err_next) tx_busy_cnt = 3;
                err_next = 0; aw_got = 0; w_got = 0;
            end
            if (WVALID && !WREADY && !w_got) WREADY = 1;
            if (AWVALID && !AWREADY && !aw_got) begin
                if (aw_stall_cfg == 0) AWREADY = 1;
                else if (w_got) begin
                    if (aw_stall_cnt > 0) aw_stall_cnt--;
                    else AWREADY = 1;
                end
            end
            ar_hs_p = ARVALID && ARREADY; ar_addr_p = ARADDR;
            r_hs_p  = RVALID && RREADY;
            aw_hs_p = AWVALID && AWREADY;
            w_hs_p  = WVALID && WREADY; w_data_p = WDATA;
            b_hs_p  = BVALID && BREADY;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int total;
        int k;
        logic [31:0] exp_c[4];
        vectors = 0; miscompares = 0;
        AXI_ARESETN = 0; REQ_VALID = '0; REQ_DATA = '0; RX_READY = 0;
        drdy = 0; rx_byte = 0; err_next = 0; aw_stall_cfg = 0;
        for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
        repeat (3) step();

        // reset values
        check("rst_arvalid", 32'(ARVALID), 0);
        check("rst_awvalid", 32'(AWVALID), 0);
        check("rst_wvalid",  32'(WVALID), 0);
        check("rst_bready",  32'(BREADY), 0);
        check("rst_rready",  32'(RREADY), 0);
        check("rst_req_ready", 32'(REQ_READY), 0);
        check("rst_rx_valid", 32'(RX_VALID), 0);
        check("rst_rx_data", 32'(RX_DATA), 0);
        check("rst_err",     32'(ERR), 0);
        check("rst_wstrb",   32'(WSTRB), 32'hF);
        check("rst_awaddr",  32'(AWADDR), 0);
        check("rst_wdata",   WDATA, 0);
        check("rst_state",   32'(dut.state), 32'(ST_IDLE));
        check("rst_rr_ptr",  32'(dut.rr_ptr), 0);
        AXI_ARESETN = 1;
        repeat (5) step();

        // all four requesters, pointer 0: 0x10..0x13 in order
        clear_logs();
        REQ_DATA = {8'h13, 8'h12, 8'h11, 8'h10};
        REQ_VALID = 4'hF;
        total = 0;
        for (k = 0; k < 2000 && total < 4; k++) begin
            step();
            total = ready_cnt[0] + ready_cnt[1] + ready_cnt[2] + ready_cnt[3];
        end
        check("all4_done", 32'(total), 4);
        repeat (10) step();
        check("all4_nwr", 32'(wr_log.size()), 4);
        exp_c = '{32'h10, 32'h11, 32'h12, 32'h13};
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("all4_data", wr_log[i], exp_c[i]);
                check("all4_prev_addr", 32'(wr_prev1[i]), 32'h4);
                check("all4_prev_busy", wr_prevd[i], 0);
            end
        end
        for (int i = 0; i < NR; i++) check("all4_ready_once", 32'(ready_cnt[i]), 1);
        check("all4_rr_ptr", 32'(dut.rr_ptr), 0);

        // single requester 1 with 0x5A
        clear_logs();
        REQ_DATA[15:8] = 8'h5A;
        REQ_VALID[1] = 1'b1;
        for (k = 0; k < 500 && ready_cnt[1] == 0; k++) step();
        check("single_done", 32'(ready_cnt[1]), 1);
        repeat (10) step();
        check("single_nwr", 32'(wr_log.size()), 1);
        if (wr_log.size() == 1) begin
            check("single_wdata", wr_log[0], 32'h0000005A);
            check("single_rd_last", 32'(wr_prev1[0]), 32'h4);
            check("single_rd_before", 32'(wr_prev2[0]), 32'hC);
        end
        check("single_ready_once", 32'(ready_cnt[1]), 1);
        check("single_rr_ptr", 32'(dut.rr_ptr), 2);

        // all four with pointer 2: grant order 2,3,0,1
        clear_logs();
        REQ_DATA = {8'h13, 8'h12, 8'h11, 8'h10};
        REQ_VALID = 4'hF;
        total = 0;
        for (k = 0; k < 2000 && total < 4; k++) begin
            step();
            total = ready_cnt[0] + ready_cnt[1] + ready_cnt[2] + ready_cnt[3];
        end
        check("rot_done", 32'(total), 4);
        repeat (10) step();
        check("rot_nwr", 32'(wr_log.size()), 4);
        exp_c = '{32'h12, 32'h13, 32'h10, 32'h11};
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("rot_order", wr_log[i], exp_c[i]);
        end

        // RX byte 0xC3 held while RX_READY is low
        clear_logs();
        RX_READY = 0;
        rx_byte = 8'hC3;
        drdy = 1'b1;
        for (k = 0; k < 300 && !RX_VALID; k++) step();
        check("rx_valid_set", 32'(RX_VALID), 1);
        check("rx_data", 32'(RX_DATA), 32'hC3);
        check("rx_one_read", 32'(count_rd(8)), 1);
        clear_logs();
        repeat (30) step();
        check("rx_hold_no_poll", 32'(count_rd(12)), 0);
        check("rx_hold_valid", 32'(RX_VALID), 1);
        RX_READY = 1;
        step();
        check("rx_consumed", 32'(RX_VALID), 0);
        for (k = 0; k < 100 && count_rd(12) == 0; k++) step();
        check("rx_poll_resumes", 32'(count_rd(12) > 0), 1);

        // RX_READY already high when RX_VALID rises
        rx_byte = 8'h3C;
        drdy = 1'b1;
        for (k = 0; k < 300 && !RX_VALID; k++) step();
        check("rx2_data", 32'(RX_DATA), 32'h3C);
        step();
        check("rx2_cleared", 32'(RX_VALID), 0);

        // error response on 0x77, then retry
        check("err_before", 32'(ERR), 0);
        clear_logs();
        err_next = 1'b1;
        REQ_DATA[7:0] = 8'h77;
        REQ_VALID[0] = 1'b1;
        for (k = 0; k < 1000 && ready_cnt[0] == 0; k++) step();
        repeat (10) step();
        check("err_sticky", 32'(ERR), 1);
        check("err_nwr", 32'(wr_log.size()), 2);
        if (wr_log.size() == 2) begin
            check("err_first_data", wr_log[0], 32'h77);
            check("err_first_resp", 32'(wr_resp[0]), 2);
            check("err_retry_data", wr_log[1], 32'h77);
            check("err_retry_resp", 32'(wr_resp[1]), 0);
        end
        check("err_ready_once", 32'(ready_cnt[0]), 1);

        // AWREADY stalled 3 cycles after WREADY
        clear_logs();
        aw_stall_cfg = 3;
        REQ_DATA[23:16] = 8'h42;
        REQ_VALID[2] = 1'b1;
        for (k = 0; k < 500 && !w_got; k++) step();
        check("stall_w_seen", 32'(w_got), 1);
        check("stall_wvalid_dropped", 32'(WVALID), 0);
        check("stall_awvalid_held", 32'(AWVALID), 1);
        for (k = 0; k < 500 && ready_cnt[2] == 0; k++) step();
        repeat (10) step();
        aw_stall_cfg = 0;
        check("stall_nwr", 32'(wr_log.size()), 1);
        if (wr_log.size() == 1) check("stall_data", wr_log[0], 32'h42);
        check("stall_ready_once", 32'(ready_cnt[2]), 1);
        check("stall_rr_ptr", 32'(dut.rr_ptr), 3);

        // asynchronous reset during a read address phase
        for (k = 0; k < 200 && !ARVALID; k++) step();
        check("arst_arvalid_seen", 32'(ARVALID), 1);
        AXI_ARESETN = 0;
        #1;
        check("arst_arvalid_drop", 32'(ARVALID), 0);
        check("arst_rready_drop", 32'(RREADY), 0);
        repeat (3) step();
        AXI_ARESETN = 1;
        #1;
        check("arst_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check("arst_rr_ptr", 32'(dut.rr_ptr), 0);
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_axil_sched.md
# uart_axil_sched

AXI4-Lite master that sequences the `uart_axi4lite` peripheral on behalf of several on-chip byte producers and one byte consumer. It arbitrates `NUM_REQ` TX byte requesters round-robin, polls `TX_BUSY` before every `TX_DATA` write, and polls `RX_STATE` and drains `RX_DATA` into a one-entry output buffer. It sits between the requesters and the UART's AXI4-Lite slave port, so software never polls the UART directly.

## Interface
Parameters:
- `NUM_REQ`, 4: number of TX requesters, 1..8.
- `AXI_AWIDTH`, 4: AXI address width.
- `AXI_DWIDTH`, 32: AXI data width.
- `DATA_BITS`, 8: UART character width.
- `TX_GUARD`, 4: idle cycles after a `TX_DATA` write before the next `TX_BUSY` poll. Minimum 1.

Ports:
- `AXI_ACLK` in 1: the single clock.
- `AXI_ARESETN` in 1: asynchronous, active-low reset.
- `REQ_VALID` in `NUM_REQ`: per-requester byte valid.
- `REQ_DATA` in `NUM_REQ*DATA_BITS`: requester i occupies bits `[i*DATA_BITS +: DATA_BITS]`.
- `REQ_READY` out `NUM_REQ`: one-cycle accept pulse.
- `RX_VALID` out 1: received byte available.
- `RX_DATA` out `DATA_BITS`: received byte.
- `RX_READY` in 1: consumer accepts the byte.
- `ERR` out 1: sticky; set on any non-OKAY `BRESP`/`RRESP`; cleared only by reset.
- `M_AXI_AWADDR`/`AWVALID`/`AWREADY`, `WDATA`/`WSTRB`/`WVALID`/`WREADY`, `BRESP`/`BVALID`/`BREADY`, `ARADDR`/`ARVALID`/`ARREADY`, `RDATA`/`RRESP`/`RVALID`/`RREADY`: standard AXI4-Lite master channels with the widths above.

## Operation
- UART register offsets:
  - 0x0: `TX_DATA` (write).
  - 0x4: `TX_BUSY` (bit0).
  - 0x8: `RX_DATA` (read; clears drdy).
  - 0xC: `RX_STATE` (bit0 = drdy, bit1 = rx_busy).
- FSM states: IDLE, POLL_RX, READ_RX, POLL_TX, WRITE_TX, GUARD.
- IDLE always moves to POLL_RX when `RX_VALID` = 0. Otherwise it moves to POLL_TX if any `REQ_VALID`, else it stays in IDLE.
- POLL_RX reads 0xC.
  - drdy = 1: go to READ_RX.
  - drdy = 0: go to POLL_TX if any `REQ_VALID` is set, else IDLE.
- READ_RX reads 0x8. `RX_DATA` ← `RDATA[DATA_BITS-1:0]` and `RX_VALID` ← 1 on the R handshake. Then go to POLL_TX if any `REQ_VALID` is set, else IDLE.
- POLL_TX reads 0x4.
  - bit0 = 1: go to IDLE (re-poll RX first).
  - bit0 = 0: the round-robin arbiter grants the lowest index at or after `rr_ptr` with `REQ_VALID` = 1. The granted byte is latched into `WDATA`; go to WRITE_TX.
  - No `REQ_VALID` at grant time: go to IDLE.
- WRITE_TX writes 0x0 with `WSTRB` = all ones.
  - `BRESP` = OKAY: pulse `REQ_READY[grant]` in the cycle after the B handshake, and set `rr_ptr` ← grant+1 mod `NUM_REQ`.
  - `BRESP` ≠ OKAY: no pulse, `rr_ptr` unchanged (byte retried).
  - Either way go to GUARD.
- GUARD counts `TX_GUARD` cycles (this covers `TX_BUSY` rise latency), then goes to IDLE.
- Requesters hold `REQ_DATA` stable while `REQ_VALID` is high. A requester may drop `REQ_VALID` before grant with no effect.
- RX buffer: `RX_VALID` clears on `RX_VALID` & `RX_READY`. While `RX_VALID` = 1, RX is not polled and the UART holds drdy.

## Timing
- All outputs are registered.
- Reset values:
  - All `*VALID`, `REQ_READY`, `RX_VALID` and `ERR` are 0; `BREADY` and `RREADY` are 0.
  - Addresses and `WDATA` are 0; `WSTRB` is 0xF.
  - `RX_DATA` is 0, `rr_ptr` is 0, state is IDLE.
- Reset asserted mid-transaction drops every valid immediately (asynchronously). No transaction is resumed.
- Write: `AWVALID` and `WVALID` rise together in the cycle after entering WRITE_TX, and `BREADY` is held high from then on. AW and W are tracked independently with done flags. Each valid drops in the cycle after its ready is sampled. The state completes on `BVALID` & `BREADY`.
- Read: `ARVALID` and `RREADY` rise together, because the slave only responds with `RREADY` high. `ARVALID` drops after `ARREADY`. The state completes on `RVALID` & `RREADY`, and `RREADY` drops in the next cycle.
- No new transaction is issued before the previous response completes; at most one is outstanding.
- Simultaneous `REQ_VALID` from all requesters with `rr_ptr` = 2 (`NUM_REQ` = 4): grant order is 2, 3, 0, 1.
- `RX_READY` in the same cycle `RX_VALID` rises: the byte is consumed and `RX_VALID` is 0 next cycle.

## Structure
- Shared package `uart_axil_pkg`: register offsets (0x0/0x4/0x8/0xC), `RESP_OKAY` = 2'b00, FSM state encoding. `uart_axi4lite` also uses the offsets.
- Sub-module `rr_arbiter`: parameter `N`. Inputs `req[N]`, `ptr`; outputs `grant_idx`, `grant_any`. Combinational.

## Test plan
- Single requester 1, `REQ_DATA` = 0x5A, UART idle: 0xC read, 0x4 read, then 0x0 write with `WDATA` = 0x0000005A. `REQ_READY[1]` pulses once and the serial line shows 0x5A.
- All 4 requesters valid with bytes 0x10..0x13: `TX_DATA` writes in order 0x10, 0x11, 0x12, 0x13, each preceded by a 0x4 read returning 0. Each `REQ_READY` pulses exactly once.
- Serial 0xC3 injected on `RX_DSER` with `RX_READY` low: one 0x8 read, `RX_VALID` = 1, `RX_DATA` = 0xC3, then no further 0xC reads. Raising `RX_READY` clears `RX_VALID` and polling resumes.
- Slave model returns `BRESP` = 2'b10 once for byte 0x77: `ERR` = 1 and no `REQ_READY` pulse. 0x77 is rewritten after GUARD and `REQ_READY` then pulses.
- Slave model stalls `AWREADY` 3 cycles after `WREADY`: `WVALID` drops after `WREADY` while `AWVALID` is held. Exactly one write completes.
- `AXI_ARESETN` asserted while `ARVALID` = 1: `ARVALID` = 0 without a clock edge. After release the FSM is in IDLE with `rr_ptr` = 0.
